left_shift_32_seq: RTL and testbench

Sequential 32-bit logical left shifter for the multi-cycle datapath, the left-direction counterpart of the combinational logical right shifter. It is a five-stage logarithmic shifter folded in time. One stage is applied per clock: 1, 2, 4, 8 or 16 positions, gated by the matching `select` bit. A start/busy/done handshake lets the controller FSM issue SLL-type operations without lengthening the ALU critical path.

---
 rtl/left_shift_32_seq.sv | 156 +++++++++++++++
 tb/tb_left_shift_32_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_32_seq.sv
// left_shift_32_seq: 32-bit logical left shifter, one log stage per clock.
// Shifts by 1, 2, 4, 8 or 16 per stage, gated by the captured select bits.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   start            request, sampled only in IDLE
//   data, select     operand and shift amount, captured when start is taken
//   res, lost        registered result and shifted-out-one flag
//   busy, done       busy while shifting, one-cycle completion pulse
// Option: define LSHIFT_EARLY_DONE_EN to stop after the highest set select bit.
module left_shift_32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  input  logic [4:0]  select,
  output logic [31:0] res,
  output logic        lost,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  sel_q, sel_d;
  logic [2:0]  stage_q, stage_d;
  logic        lost_acc_q, lost_acc_d;
  logic        lost_q, lost_d;
  logic        done_q, done_d;

  logic [31:0] sh_acc;
  logic        sh_lost;
  logic        last;

  // One log-shifter stage; sh_lost is the OR of the bits pushed past bit 31.
  always_comb begin
    sh_acc  = acc_q;
    sh_lost = 1'b0;
    last    = 1'b0;
    case (stage_q)
      3'd0: begin
        if (sel_q[0]) begin
          sh_acc  = {acc_q[30:0], 1'b0};
          sh_lost = acc_q[31];
        end
`ifdef LSHIFT_EARLY_DONE_EN
        last = (sel_q[4:1] == 4'd0);
`endif
      end
      3'd1: begin
        if (sel_q[1]) begin
          sh_acc  = {acc_q[29:0], 2'b0};
          sh_lost = |acc_q[31:30];
        end
`ifdef LSHIFT_EARLY_DONE_EN
        last = (sel_q[4:2] == 3'd0);
`endif
      end
      3'd2: begin
        if (sel_q[2]) begin
          sh_acc  = {acc_q[27:0], 4'b0};
          sh_lost = |acc_q[31:28];
        end
`ifdef LSHIFT_EARLY_DONE_EN
        last = (sel_q[4:3] == 2'd0);
`endif
      end
      3'd3: begin
        if (sel_q[3]) begin
          sh_acc  = {acc_q[23:0], 8'b0};
          sh_lost = |acc_q[31:24];
        end
`ifdef LSHIFT_EARLY_DONE_EN
        last = ~sel_q[4];
`endif
      end
      3'd4: begin
        if (sel_q[4]) begin
          sh_acc  = {acc_q[15:0], 16'b0};
          sh_lost = |acc_q[31:16];
        end
        last = 1'b1;
      end
      default: begin
        last = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sel_d      = sel_q;
    stage_d    = stage_q;
    lost_acc_d = lost_acc_q;
    res_d      = res_q;
    lost_d     = lost_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          acc_d      = data;
          sel_d      = select;
          stage_d    = 3'd0;
          lost_acc_d = 1'b0;
        end
      end
      SHIFT: begin
        acc_d      = sh_acc;
        lost_acc_d = lost_acc_q | sh_lost;
        stage_d    = stage_q + 3'd1;
        if (last) begin
          state_d = IDLE;
          stage_d = 3'd0;
          res_d   = sh_acc;
          lost_d  = lost_acc_q | sh_lost;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= 32'h0;
      sel_q      <= 5'd0;
      stage_q    <= 3'd0;
      lost_acc_q <= 1'b0;
      res_q      <= 32'h0;
      lost_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sel_q      <= sel_d;
      stage_q    <= stage_d;
      lost_acc_q <= lost_acc_d;
      res_q      <= res_d;
      lost_q     <= lost_d;
      done_q     <= done_d;
    end
  end

  assign res  = res_q;
  assign lost = lost_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_left_shift_32_seq.sv
// tb_left_shift_32_seq: vector table, scoreboard and handshake corner cases
// for left_shift_32_seq.
module tb_left_shift_32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [4:0]  select;
  logic [31:0] res;
  logic        lost;
  logic        busy;
  logic        done;

  left_shift_32_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data   (data),
    .select (select),
    .res    (res),
    .lost   (lost),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] r;
    logic        l;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   done_count;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: shift into a 64-bit word; anything above bit 31 was lost.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] w;
    exp_t e;
    w = {32'h0, d} << s;
    e.r = w[31:0];
    e.l = |w[63:32];
    return e;
  endfunction

  function automatic int exp_lat(input logic [4:0] s);
`ifdef LSHIFT_EARLY_DONE_EN
    int h;
    h = 0;
    for (int i = 0; i < 5; i++)
      if (s[i]) h = i;
    return h + 1;
`else
    return 5;
`endif
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res", res, e.r);
        chk("lost", {31'b0, lost}, {31'b0, e.l});
      end
    end
  end

  // Called right after an edge (+1); start is sampled at the next edge.
  task automatic start_op(input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    e = model(d, s);
    sb.push_back(e);
    start  = 1'b1;
    data   = d;
    select = s;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data   = $urandom;
    select = 5'($urandom);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int lat, input int n0,
                           input logic [31:0] hold);
    int n;
    bit ok;
    n  = n0;
    ok = 1'b1;
    while (done !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (done !== 1'b1 && (res !== hold || busy !== 1'b1)) ok = 1'b0;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("latency", n, lat);
    chk("hold_while_busy", {31'b0, ok}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] s);
    logic [31:0] hold;
    hold = res;
    start_op(d, s);
    wait_done(exp_lat(s), 0, hold);
  endtask

  vec_t vt[13];

  initial begin
    int dc;
    logic [31:0] hold;
    checks     = 0;
    failures   = 0;
    done_count = 0;

    vt[0]  = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vt[1]  = '{32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b1};
    vt[2]  = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    vt[3]  = '{32'h0000_0003, 5'd2,  32'h0000_000C, 1'b0};
    vt[4]  = '{32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00, 1'b1};
    vt[5]  = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};
    vt[6]  = '{32'h4000_0000, 5'd1,  32'h8000_0000, 1'b0};
    vt[7]  = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1};
    vt[8]  = '{32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000, 1'b1};
    vt[9]  = '{32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0};
    vt[10] = '{32'h0001_0000, 5'd15, 32'h8000_0000, 1'b0};
    vt[11] = '{32'h0002_0000, 5'd15, 32'h0000_0000, 1'b1};
    vt[12] = '{32'h0000_0007, 5'd3,  32'h0000_0038, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    data   = 32'h0;
    select = 5'd0;
    #1;
    chk("rst_res", res, 32'h0);
    chk("rst_lost", {31'b0, lost}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors: expected values from the table, model cross-checked.
    foreach (vt[i]) begin
      exp_t m;
      m = model(vt[i].d, vt[i].s);
      chk("model_vs_table", {m.l, m.r[30:0]}, {vt[i].l, vt[i].r[30:0]});
      run_op(vt[i].d, vt[i].s);
      chk("tbl_res", res, vt[i].r);
      chk("tbl_lost", {31'b0, lost}, {31'b0, vt[i].l});
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'b0, done}, 32'd0);
    end

    // Start while busy is ignored.
    dc   = done_count;
    hold = res;
    start_op(32'hFFFF_FFFF, 5'd8);
    @(posedge clk);
    #1;
    start  = 1'b1;
    data   = 32'h0;
    select = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(exp_lat(5'd8), 2, hold);
    chk("ign_res", res, 32'hFFFF_FF00);
    chk("ign_lost", {31'b0, lost}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("ign_single_done", done_count - dc, 1);

    // Back-to-back: start raised in the done cycle.
    run_op(32'h0000_0010, 5'd1);
    hold = res;
    start_op(32'h0000_0003, 5'd2);
    wait_done(exp_lat(5'd2), 0, hold);
    chk("b2b_res", res, 32'h0000_000C);

    // Reset in the middle of an operation.
    @(posedge clk);
    #1;
    start_op(32'h0000_0001, 5'd5);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_res", res, 32'h0);
    chk("mid_rst_lost", {31'b0, lost}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = done_count;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_count - dc, 0);
    run_op(32'h0000_0003, 5'd2);
    chk("post_rst_res", res, 32'h0000_000C);

    // Random operands through the scoreboard.
    for (int i = 0; i < 200; i++) begin
      run_op($urandom, 5'($urandom));
    end
    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
